// File: rtl/clk_sched_ctrl_if.sv
// Handshake and output bundle for clk_sched_ctrl: run request, ratio update channel, divided clock outputs.
interface clk_sched_ctrl_if #(
    parameter int DIV_W = 8
);
    logic             en;
    logic             cfg_valid;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;
    logic             clk_out;
    logic             tick;
    logic             busy;
    logic [7:0]       toggle_counter;

    modport master (
        output en, cfg_valid, cfg_div,
        input  cfg_ready, cfg_err, clk_out, tick, busy, toggle_counter
    );

    modport slave (
        input  en, cfg_valid, cfg_div,
        output cfg_ready, cfg_err, clk_out, tick, busy, toggle_counter
    );
endinterface

// File: rtl/clk_sched_ctrl.sv
// Run/stop and divide-ratio controller producing a runt-free divided clock; ratio changes land on period ends.
// Optional clk_out transition counter is built when CLK_SCHED_TOGGLE_CNT_EN is defined.
module clk_sched_ctrl #(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input logic             clk_in,
    input logic             rst_n,
    clk_sched_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_divCur;
    logic [DIV_W-1:0] r_pendingDiv;
    logic             r_pending;
    logic             r_clkOut;
    logic             r_cfgErr;

    logic [DIV_W-1:0] w_cntNext;
    logic [DIV_W-1:0] w_divNext;
    logic             w_lastCnt;
    logic             w_accept;
    logic             w_cfgLegal;
    logic             w_pendingSet;
    logic             w_clkOutNext;
    logic             w_tick;
    logic             w_busy;
    logic             w_cfgReady;

    assign w_lastCnt  = (r_state != IDLE) && (r_cnt == r_divCur - DIV_W'(1));
    assign w_accept   = bus.cfg_valid && w_cfgReady;
    assign w_cfgLegal = (bus.cfg_div >= DIV_W'(2));

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE: begin
                if (bus.en) w_nextState = RUN;
            end
            RUN: begin
                if (!bus.en) w_nextState = w_lastCnt ? IDLE : STOPPING;
            end
            STOPPING: begin
                if (bus.en)         w_nextState = RUN;
                else if (w_lastCnt) w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        w_tick     = w_lastCnt;
        w_busy     = (r_state != IDLE);
        w_cfgReady = !r_pending;
    end

    // A legal ratio taken while running waits in pending, unless the block is idle or about to be.
    always_comb begin
        w_cntNext = '0;
        if ((r_state != IDLE) && (w_nextState != IDLE) && !w_lastCnt) begin
            w_cntNext = r_cnt + DIV_W'(1);
        end

        w_divNext    = r_divCur;
        w_pendingSet = 1'b0;
        if (w_lastCnt && r_pending) begin
            w_divNext = r_pendingDiv;
        end else if (w_accept && w_cfgLegal) begin
            if ((r_state == IDLE) || (w_nextState == IDLE)) begin
                w_divNext = bus.cfg_div;
            end else begin
                w_pendingSet = 1'b1;
            end
        end

        w_clkOutNext = (w_nextState != IDLE) && (w_cntNext < (w_divNext >> 1));
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_divCur     <= DIV_W'(DEFAULT_DIV);
            r_pending    <= 1'b0;
            r_pendingDiv <= '0;
            r_clkOut     <= 1'b0;
            r_cfgErr     <= 1'b0;
        end else begin
            r_cnt    <= w_cntNext;
            r_divCur <= w_divNext;
            r_clkOut <= w_clkOutNext;
            r_cfgErr <= w_accept && !w_cfgLegal;
            if (w_pendingSet) begin
                r_pending    <= 1'b1;
                r_pendingDiv <= bus.cfg_div;
            end else if (w_lastCnt && r_pending) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign bus.clk_out   = r_clkOut;
    assign bus.tick      = w_tick;
    assign bus.busy      = w_busy;
    assign bus.cfg_ready = w_cfgReady;
    assign bus.cfg_err   = r_cfgErr;

`ifdef CLK_SCHED_TOGGLE_CNT_EN
    logic [7:0] r_toggleCnt;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_toggleCnt <= 8'h00;
        end else if (w_clkOutNext != r_clkOut) begin
            r_toggleCnt <= r_toggleCnt + 8'h01;
        end
    end

    assign bus.toggle_counter = r_toggleCnt;
`else
    assign bus.toggle_counter = 8'h00;
`endif
endmodule

// File: tb/tb_clk_sched_ctrl.sv
// Scoreboard bench for clk_sched_ctrl: directed scenarios plus random traffic against an integer reference model.
module tb_clk_sched_ctrl;
    localparam int DIV_W       = 8;
    localparam int DEFAULT_DIV = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    clk_sched_ctrl_if #(.DIV_W(DIV_W)) bus();

    clk_sched_ctrl #(.DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV)) dut (
        .clk_in(clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit clkOut;
        bit tick;
        bit busy;
        bit ready;
        bit err;
        int tog;
        int cycle;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   cycleNo = 0;

    // Reference model: mState 0 = idle, 1 = running, 2 = stopping; mPend 0 means nothing pending.
    int mState, mCnt, mDiv, mPend, mTog;
    bit mClk, mErr;

    function automatic void modelReset();
        mState = 0; mCnt = 0; mDiv = DEFAULT_DIV; mPend = 0;
        mTog = 0; mClk = 1'b0; mErr = 1'b0;
    endfunction

    function automatic void modelStep(bit en, bit valid, int div);
        bit periodEnd = (mState != 0) && (mCnt == mDiv - 1);
        bit take      = valid && (mPend == 0);
        bit newClk;
        int nState;
        if (mState == 0)     nState = en ? 1 : 0;
        else if (en)         nState = 1;
        else if (periodEnd)  nState = 0;
        else                 nState = 2;
        mErr = take && (div < 2);
        if (periodEnd && mPend != 0) begin
            mDiv  = mPend;
            mPend = 0;
        end else if (take && div >= 2) begin
            if (mState == 0 || nState == 0) mDiv = div;
            else                            mPend = div;
        end
        if (mState == 0 || nState == 0 || periodEnd) mCnt = 0;
        else                                         mCnt = mCnt + 1;
        mState = nState;
        newClk = (mState != 0) && (mCnt < mDiv / 2);
        if (newClk != mClk) mTog = (mTog + 1) % 256;
        mClk = newClk;
    endfunction

    function automatic exp_t modelOutputs();
        exp_t e;
        e.clkOut = mClk;
        e.tick   = (mState != 0) && (mCnt == mDiv - 1);
        e.busy   = (mState != 0);
        e.ready  = (mPend == 0);
        e.err    = mErr;
`ifdef CLK_SCHED_TOGGLE_CNT_EN
        e.tog    = mTog;
`else
        e.tog    = 0;
`endif
        e.cycle  = cycleNo;
        return e;
    endfunction

    task automatic applyStimulus(input bit rstn, input bit en, input bit valid, input int div);
        @(negedge clk);
        rst_n         = rstn;
        bus.en        = en;
        bus.cfg_valid = valid;
        bus.cfg_div   = DIV_W'(div);
        cycleNo++;
        if (!rstn) modelReset();
        else       modelStep(en, valid, div);
        expQ.push_back(modelOutputs());
    endtask

    task automatic runCycles(input int n, input bit en);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, en, 1'b0, 0);
    endtask

    task automatic runUntilCnt(input int target, input bit en);
        int guard = 0;
        while (!(mState != 0 && mCnt == target) && guard < 600) begin
            applyStimulus(1'b1, en, 1'b0, 0);
            guard++;
        end
        checks++;
        if (guard >= 600) begin
            errors++;
            $display("[TB] FAIL wait_cnt: model count %0d never reached required %0d", mCnt, target);
        end
    endtask

    task automatic checkField(input string name, input int act, input int exp, input int cyc);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        checkField("clk_out",        int'(bus.clk_out),        int'(e.clkOut), e.cycle);
        checkField("tick",           int'(bus.tick),           int'(e.tick),   e.cycle);
        checkField("busy",           int'(bus.busy),           int'(e.busy),   e.cycle);
        checkField("cfg_ready",      int'(bus.cfg_ready),      int'(e.ready),  e.cycle);
        checkField("cfg_err",        int'(bus.cfg_err),        int'(e.err),    e.cycle);
        checkField("toggle_counter", int'(bus.toggle_counter), e.tog,          e.cycle);
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    initial begin : driver
        bus.en = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_div = '0;
        modelReset();

        // Default ratio 4: four full periods plus margin.
        applyStimulus(1'b0, 1'b0, 1'b0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 0);
        runCycles(2, 1'b0);
        runCycles(18, 1'b1);

        // Odd ratio 5 loaded while idle.
        runCycles(6, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 5);
        runCycles(16, 1'b1);

        // Mid-period update from 4 to 6.
        runCycles(8, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 4);
        runCycles(1, 1'b1);
        runUntilCnt(1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 6);
        runCycles(16, 1'b1);

        // Stop request mid-period at ratio 8, then a cancelled stop.
        runCycles(8, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 8);
        runCycles(1, 1'b1);
        runUntilCnt(2, 1'b1);
        runCycles(10, 1'b0);
        runCycles(1, 1'b1);
        runUntilCnt(2, 1'b1);
        runUntilCnt(5, 1'b0);
        runCycles(12, 1'b1);

        // Illegal ratios 1 and 0 while running at 4.
        runCycles(10, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 4);
        runCycles(3, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1);
        runCycles(2, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 0);
        runCycles(10, 1'b1);

        // Reset mid-period with a pending ratio.
        runCycles(6, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 6);
        runCycles(1, 1'b1);
        runUntilCnt(1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 3);
        runUntilCnt(3, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 0);
        runCycles(1, 1'b0);
        runCycles(12, 1'b1);

        // Random traffic.
        begin
            bit en = 1'b1;
            for (int i = 0; i < 3000; i++) begin
                bit rstn  = ($urandom_range(0, 499) != 0);
                bit valid = ($urandom_range(0, 4) == 0);
                int div   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 40))
                                                        : int'($urandom_range(0, 10));
                if ($urandom_range(0, 11) == 0) en = ~en;
                applyStimulus(rstn, en, valid, div);
            end
        end

        @(posedge clk);
        #2;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left expected 0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
